im_uart_loader: RTL and testbench

//  Writer side of the instruction-memory interface: receives a program image over a UART RX line
//  and writes it word-by-word into instruction memory, which the CPU then reads as rom_addr/instr.

---
 rtl/im_uart_loader_pkg.sv | 16 +
 rtl/im_uart_loader_if.sv | 11 +
 rtl/im_uart_loader_rx.sv | 88 ++++++++
 rtl/im_uart_loader.sv | 92 +++++++++
 tb/tb_im_uart_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/im_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader: RX state encoding
// and the bit-period helper.
package im_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/im_uart_loader_if.sv
// Instruction-memory write port driven by the loader; the IM side uses the slave view.
interface im_uart_loader_if #(
    parameter int ADDR_W = 6
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

    modport master (output we, addr, wdata);
    modport slave  (input  we, addr, wdata);
endinterface

// File: rtl/im_uart_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling FSM, sticky framing error.
module uart_rx_byte
    import im_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       frame_err_o,
    output logic       idle_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state;
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_s;

    assign rx_s   = sync[1];
    assign idle_o = (state == IDLE);

    // NOTE: every register here is updated with <= so all branches see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            // Synchronizer resets to the idle-high line level so no false start is seen.
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            byte_o      <= '0;
            byte_vld_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync       <= {sync[0], rx_i};
            byte_vld_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (en && !rx_s) state <= START;
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            byte_o     <= shreg;
                            byte_vld_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/im_uart_loader.sv
// Loads a program image received over UART into instruction memory, little-endian
// words at consecutive addresses; finishes when memory is full or the line goes idle.
module im_uart_loader
    import im_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 6,
    parameter int IDLE_TO  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rx_i,
    input  logic                load_en_i,
    im_uart_loader_if.master    im,
    output logic                busy_o,
    output logic                done_o,
    output logic                frame_err_o,
    output logic [ADDR_W:0]     word_cnt_o
);
    localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TO_CYC = IDLE_TO * CPB;
    localparam int TO_W   = $clog2(TO_CYC);

    logic [7:0]        rx_byte;
    logic              rx_vld;
    logic              rx_idle;
    logic [1:0]        byte_idx;
    logic [23:0]       word_lo;
    logic [ADDR_W-1:0] addr;
    logic [TO_W-1:0]   to_cnt;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .clr         (!load_en_i),
        .en          (!done_o),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .byte_vld_o  (rx_vld),
        .frame_err_o (frame_err_o),
        .idle_o      (rx_idle)
    );

    always_ff @(posedge clk) begin
        if (rst || !load_en_i) begin
            im.we      <= 1'b0;
            im.addr    <= '0;
            im.wdata   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            word_cnt_o <= '0;
            byte_idx   <= '0;
            word_lo    <= '0;
            addr       <= '0;
            to_cnt     <= '0;
        end else begin
            im.we  <= 1'b0;
            busy_o <= !done_o;

            // Lower three bytes shift in from the top so byte k lands at word[8k+7:8k].
            if (rx_vld && !done_o) begin
                if (byte_idx == 2'd3) begin
                    im.we      <= 1'b1;
                    im.addr    <= addr;
                    im.wdata   <= {rx_byte, word_lo};
                    word_cnt_o <= word_cnt_o + 1'b1;
                    byte_idx   <= '0;
                    if (addr == '1) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    word_lo  <= {rx_byte, word_lo[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                end
            end

            // Idle timeout only armed once a word exists; pending partial bytes are dropped.
            if (word_cnt_o == '0 || !rx_idle || done_o) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TO_CYC - 1)) begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_im_uart_loader.sv
// Directed bench for im_uart_loader at 16 clk/bit, 4-word IM, 4-bit-period idle timeout.
module tb_im_uart_loader;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int ADDR_W   = 2;
    localparam int IDLE_TO  = 4;
    localparam int CPB      = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic              done;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            uart_rx = 1'b1;
    logic            load_en = 1'b0;
    logic            busy, done, ferr;
    logic [ADDR_W:0] wcnt;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t wq[$];

    im_uart_loader_if #(.ADDR_W(ADDR_W)) im ();

    im_uart_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ADDR_W   (ADDR_W),
        .IDLE_TO  (IDLE_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx_i   (uart_rx),
        .load_en_i   (load_en),
        .im          (im),
        .busy_o      (busy),
        .done_o      (done),
        .frame_err_o (ferr),
        .word_cnt_o  (wcnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im.we === 1'b1) wq.push_back('{addr: im.addr, data: im.wdata, done: done});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int i, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input logic dn);
        if (i < wq.size()) begin
            check({tag, "_addr"}, 64'(wq[i].addr), 64'(a));
            check({tag, "_data"}, 64'(wq[i].data), 64'(d));
            check({tag, "_done"}, 64'(wq[i].done), 64'(dn));
        end else begin
            check({tag, "_present"}, 64'(wq.size()), 64'(i + 1));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    task automatic restart();
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        wq.delete();
        load_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, load_en already high: rst must dominate.
        rst = 1'b1; load_en = 1'b1; uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_we",   64'(im.we), 64'd0);
        check("rst_busy", 64'(busy),  64'd0);
        check("rst_done", 64'(done),  64'd0);
        check("rst_ferr", 64'(ferr),  64'd0);
        check("rst_wcnt", 64'(wcnt),  64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("en_busy", 64'(busy), 64'd1);

        // 1: single word
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        check("t1_nwr", 64'(wq.size()), 64'd1);
        check_wr("t1_w0", 0, 2'd0, 32'h0000_0513, 1'b0);
        check("t1_wcnt", 64'(wcnt), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_done", 64'(done), 64'd0);

        // 2: fill memory, then an extra byte
        restart();
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check("t2_nwr", 64'(wq.size()), 64'd4);
        check_wr("t2_w0", 0, 2'd0, 32'h0302_0100, 1'b0);
        check_wr("t2_w1", 1, 2'd1, 32'h0706_0504, 1'b0);
        check_wr("t2_w2", 2, 2'd2, 32'h0B0A_0908, 1'b0);
        check_wr("t2_w3", 3, 2'd3, 32'h0F0E_0D0C, 1'b1);
        send_byte(8'h55);
        repeat (20) @(negedge clk);
        check("t2_nwr17", 64'(wq.size()), 64'd4);
        check("t2_done",  64'(done), 64'd1);
        check("t2_wcnt",  64'(wcnt), 64'd4);
        check("t2_busy",  64'(busy), 64'd0);

        // 3a: idle timeout after one word
        restart();
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check("t3_done_early", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        check("t3_done_mid", 64'(done), 64'd0);
        wait_done("t3_done_to", 40);
        check("t3_nwr", 64'(wq.size()), 64'd1);
        check_wr("t3_w0", 0, 2'd0, 32'hEFBE_ADDE, 1'b0);

        // 3b: timeout with two bytes pending
        restart();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hA1); send_byte(8'hA2);
        wait_done("t3p_done_to", 100);
        repeat (4) @(negedge clk);
        check("t3p_nwr",  64'(wq.size()), 64'd1);
        check_wr("t3p_w0", 0, 2'd0, 32'h0403_0201, 1'b0);
        check("t3p_wcnt", 64'(wcnt), 64'd1);

        // 4: framing error drops the byte
        restart();
        send_byte(8'hAA, 1'b0);
        repeat (32) @(negedge clk);
        check("t4_ferr", 64'(ferr), 64'd1);
        check("t4_wcnt", 64'(wcnt), 64'd0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t4_nwr", 64'(wq.size()), 64'd1);
        check_wr("t4_w0", 0, 2'd0, 32'h4433_2211, 1'b0);
        check("t4_ferr_sticky", 64'(ferr), 64'd1);

        // 5: short low glitch is not a start bit
        restart();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_nwr",  64'(wq.size()), 64'd0);
        check("t5_ferr", 64'(ferr), 64'd0);
        check("t5_busy", 64'(busy), 64'd1);
        send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
        check("t5_nwr2", 64'(wq.size()), 64'd1);
        check_wr("t5_w0", 0, 2'd0, 32'hC3C2_C1C0, 1'b0);

        // 6a: load_en drop mid-word
        restart();
        send_byte(8'hAA); send_byte(8'hBB);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_wcnt_clr", 64'(wcnt), 64'd0);
        check("t6_busy_clr", 64'(busy), 64'd0);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        check("t6_nwr", 64'(wq.size()), 64'd1);
        check_wr("t6_w0", 0, 2'd0, 32'h0403_0201, 1'b0);

        // 6b: rst mid-byte
        restart();
        send_byte(8'hAA); send_byte(8'hBB);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t6r_wcnt", 64'(wcnt), 64'd0);
        check("t6r_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h5A); send_byte(8'h6B); send_byte(8'h7C); send_byte(8'h8D);
        check("t6r_nwr", 64'(wq.size()), 64'd1);
        check_wr("t6r_w0", 0, 2'd0, 32'h8D7C_6B5A, 1'b0);
        check("t6r_wcnt2", 64'(wcnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
